// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port SRAM macro: turns write/read burst requests into
// per-beat macro strobes and buffers read data in a 2-entry FIFO with a last-beat flag.
module sram_burst_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 16,
    parameter int LW         = $clog2(MAX_BURST)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic                    REQ_WE,
    input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [LW-1:0]           REQ_LEN,
    input  logic [DATA_WIDTH/8-1:0] REQ_BE,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic                    WDATA_VALID,
    output logic                    WDATA_READY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    RDATA_VALID,
    input  logic                    RDATA_READY,
    output logic                    RDATA_LAST,
    output logic                    BUSY,
    output logic [ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic [DATA_WIDTH-1:0]   SRAM_DIN,
    output logic [DATA_WIDTH-1:0]   SRAM_BM,
    output logic                    SRAM_MEN,
    output logic                    SRAM_WEN,
    output logic                    SRAM_REN,
    input  logic [DATA_WIDTH-1:0]   SRAM_DOUT
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LW-1:0]           cnt_q;
    logic [NB-1:0]           be_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;

    logic                    wr_fire;
    logic                    rd_fire;
    logic                    beat_fire;
    logic                    fifo_valid;
    logic                    pop;
    logic                    push;
    logic [2:0]              pending_d;
    logic [1:0]              count_d;

    assign wr_fire    = (state_q == WRITE) && WDATA_VALID;
    assign fifo_valid = (count_q != 2'd0);
    assign pop        = fifo_valid && RDATA_READY;
    assign push       = inflight_q;

    // A head popped this cycle frees its slot in time for the beat issued now,
    // which is what lets a ready consumer sustain one beat per cycle.
    assign pending_d  = {1'b0, count_q} - {2'b0, pop} + {2'b0, inflight_q};
    assign rd_fire    = (state_q == READ) && (pending_d < 3'd2);
    assign beat_fire  = wr_fire || rd_fire;
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            be_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (REQ_VALID) begin
                        addr_q  <= REQ_ADDR;
                        cnt_q   <= REQ_LEN;
                        be_q    <= REQ_BE;
                        state_q <= REQ_WE ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    if (beat_fire) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - LW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            inflight_q      <= rd_fire;
            inflight_last_q <= rd_fire && (cnt_q == '0);

            if (push) begin
                fifo_data_q[wr_ptr_q] <= SRAM_DOUT;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign REQ_READY   = (state_q == IDLE);
    assign WDATA_READY = (state_q == WRITE);
    assign SRAM_WEN    = wr_fire;
    assign SRAM_REN    = rd_fire;
    assign SRAM_MEN    = wr_fire || rd_fire;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DIN    = wr_fire ? WDATA : '0;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bm
            assign SRAM_BM[8*gi +: 8] = {8{be_q[gi]}};
        end
    endgenerate

    assign RDATA_VALID = fifo_valid;
    assign RDATA       = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign RDATA_LAST  = fifo_valid && fifo_last_q[rd_ptr_q];
    assign BUSY        = (state_q != IDLE) || fifo_valid || inflight_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: a behavioural SRAM macro plus expected-write
// and expected-read queues filled at request time and drained by a negedge monitor.
module tb_sram_burst_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MB = 16;
    localparam int LW = 4;
    localparam int NB = DW / 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          REQ_VALID, REQ_READY, REQ_WE;
    logic [AW-1:0] REQ_ADDR;
    logic [LW-1:0] REQ_LEN;
    logic [NB-1:0] REQ_BE;
    logic [DW-1:0] WDATA;
    logic          WDATA_VALID, WDATA_READY;
    logic [DW-1:0] RDATA;
    logic          RDATA_VALID, RDATA_READY, RDATA_LAST, BUSY;
    logic [AW-1:0] SRAM_ADDR;
    logic [DW-1:0] SRAM_DIN, SRAM_BM, SRAM_DOUT;
    logic          SRAM_MEN, SRAM_WEN, SRAM_REN;

    always #5 CLK = ~CLK;

    sram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_BE(REQ_BE),
        .WDATA(WDATA), .WDATA_VALID(WDATA_VALID), .WDATA_READY(WDATA_READY),
        .RDATA(RDATA), .RDATA_VALID(RDATA_VALID), .RDATA_READY(RDATA_READY),
        .RDATA_LAST(RDATA_LAST), .BUSY(BUSY),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DIN(SRAM_DIN), .SRAM_BM(SRAM_BM),
        .SRAM_MEN(SRAM_MEN), .SRAM_WEN(SRAM_WEN), .SRAM_REN(SRAM_REN),
        .SRAM_DOUT(SRAM_DOUT)
    );

    function automatic logic [DW-1:0] pat(int a);
        return 32'h5A000000 | (32'(a) * 32'h00001001);
    endfunction

    // Behavioural macro: masked write, one-cycle read latency.
    logic [DW-1:0] sram_mem [1 << AW];
    bit            mem_init = 1'b0;
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else begin
            if (SRAM_MEN && SRAM_WEN)
                sram_mem[SRAM_ADDR] <= (sram_mem[SRAM_ADDR] & ~SRAM_BM) | (SRAM_DIN & SRAM_BM);
            if (SRAM_REN) SRAM_DOUT <= sram_mem[SRAM_ADDR];
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] bm;
    } wr_t;

    logic [DW-1:0] ref_mem [1 << AW];
    wr_t           wq [$];
    logic [DW:0]   rq [$];
    logic [AW-1:0] raq [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            ren_count = 0;

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (SRAM_MEN || SRAM_WEN || SRAM_REN) begin
                vectors++;
                if (SRAM_MEN !== (SRAM_WEN | SRAM_REN) || (SRAM_WEN && SRAM_REN)) begin
                    miscompares++;
                    $display("FAIL strobes: MEN=%b WEN=%b REN=%b, required MEN=WEN|REN and not both", SRAM_MEN, SRAM_WEN, SRAM_REN);
                end
            end
            if (SRAM_WEN) begin
                vectors++;
                if (wq.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: write at %h data %h, required no write", SRAM_ADDR, SRAM_DIN);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    if (SRAM_ADDR !== e.addr || SRAM_DIN !== e.data || SRAM_BM !== e.bm) begin
                        miscompares++;
                        $display("FAIL wr_beat: addr %h din %h bm %h, required addr %h din %h bm %h", SRAM_ADDR, SRAM_DIN, SRAM_BM, e.addr, e.data, e.bm);
                    end
                end
            end
            if (SRAM_REN) begin
                ren_count++;
                vectors++;
                if (raq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected: read at %h, required no read", SRAM_ADDR);
                end else begin
                    logic [AW-1:0] ea;
                    ea = raq.pop_front();
                    if (SRAM_ADDR !== ea) begin
                        miscompares++;
                        $display("FAIL rd_addr: got %h, required %h", SRAM_ADDR, ea);
                    end
                end
            end
            if (RDATA_VALID && RDATA_READY) begin
                vectors++;
                if (rq.size() == 0) begin
                    miscompares++;
                    $display("FAIL rdata_unexpected: beat %h last %b, required none", RDATA, RDATA_LAST);
                end else begin
                    logic [DW:0] er;
                    er = rq.pop_front();
                    if ({RDATA_LAST, RDATA} !== er) begin
                        miscompares++;
                        $display("FAIL rdata: got last %b data %h, required last %b data %h", RDATA_LAST, RDATA, er[DW], er[DW-1:0]);
                    end
                end
            end
        end
    end

    task automatic push_write(input logic [AW-1:0] addr, input int len, input logic [NB-1:0] be, input logic [DW-1:0] base);
        logic [DW-1:0] bm;
        wr_t           e;
        for (int b = 0; b < NB; b++) bm[8*b +: 8] = {8{be[b]}};
        for (int i = 0; i <= len; i++) begin
            e.addr = addr + AW'(i);
            e.data = base + DW'(i);
            e.bm   = bm;
            wq.push_back(e);
            ref_mem[e.addr] = (ref_mem[e.addr] & ~bm) | (e.data & bm);
        end
    endtask

    task automatic push_read(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i <= len; i++) begin
            a = addr + AW'(i);
            raq.push_back(a);
            rq.push_back({(i == len), ref_mem[a]});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic issue_req(input logic we, input logic [AW-1:0] addr, input int len,
                             input logic [NB-1:0] be, output int waited);
        REQ_WE = we; REQ_ADDR = addr; REQ_LEN = LW'(len); REQ_BE = be; REQ_VALID = 1'b1;
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
        end while (!REQ_READY && waited < 50);
        if (!REQ_READY) begin
            vectors++; miscompares++;
            $display("FAIL req_handshake: REQ_READY 0 after %0d cycles, required 1", waited);
        end
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic drive_wdata(input logic [DW-1:0] base, input int len, input bit gap);
        int k;
        for (int i = 0; i <= len; i++) begin
            if (gap && i == 1) begin
                WDATA_VALID = 1'b0;
                @(posedge CLK); #1;
            end
            WDATA = base + DW'(i);
            WDATA_VALID = 1'b1;
            k = 0;
            do begin
                @(negedge CLK);
                k++;
            end while (!WDATA_READY && k < 50);
            if (!WDATA_READY) begin
                vectors++; miscompares++;
                $display("FAIL wdata_handshake: WDATA_READY 0 after %0d cycles, required 1", k);
            end
            @(posedge CLK); #1;
        end
        WDATA_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((rq.size() != 0 || wq.size() != 0) && k < 60) begin
            @(negedge CLK); #1;
            k++;
        end
        vectors++;
        if (rq.size() != 0 || wq.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d reads %0d writes outstanding, required 0", name, rq.size(), wq.size());
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({REQ_READY, WDATA_READY, RDATA_VALID, RDATA_LAST, BUSY, SRAM_MEN, SRAM_WEN, SRAM_REN} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: RR WR RV RL BUSY MEN WEN REN = %b, required 10000000",
                     {REQ_READY, WDATA_READY, RDATA_VALID, RDATA_LAST, BUSY, SRAM_MEN, SRAM_WEN, SRAM_REN});
        end
        vectors++;
        if (SRAM_ADDR !== '0 || SRAM_DIN !== '0 || SRAM_BM !== '0 || RDATA !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h din %h bm %h rdata %h, required all 0", SRAM_ADDR, SRAM_DIN, SRAM_BM, RDATA);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    task automatic test_write();
        int w;
        push_write(10'h010, 3, 4'hF, 32'h000000A0);
        issue_req(1'b1, 10'h010, 3, 4'hF, w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("FAIL first_req_after_reset: accepted after %0d edges, required 1", w);
        end
        drive_wdata(32'h000000A0, 3, 1'b0);
        @(negedge CLK);
        vectors++;
        if (REQ_READY !== 1'b1 || WDATA_READY !== 1'b0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL write_idle: REQ_READY %b WDATA_READY %b BUSY %b, required 1 0 0", REQ_READY, WDATA_READY, BUSY);
        end
        @(posedge CLK); #1;
        wait_drain("write");
    endtask

    task automatic test_byte_enable();
        int w;
        push_write(10'h011, 1, 4'h5, 32'h11223344);
        issue_req(1'b1, 10'h011, 1, 4'h5, w);
        drive_wdata(32'h11223344, 1, 1'b1);
        wait_drain("byte_enable");
        // Read back the partially overwritten words from the earlier burst.
        push_read(10'h010, 3);
        issue_req(1'b0, 10'h010, 3, '0, w);
        wait_drain("readback");
    endtask

    task automatic test_read_wrap();
        int w, lat, n;
        push_read(10'h3FE, 3);
        issue_req(1'b0, 10'h3FE, 3, '0, w);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat == 1) begin
                vectors++;
                if (SRAM_REN !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ren_latency: SRAM_REN %b one cycle after handshake, required 1", SRAM_REN);
                end
            end
        end while (!RDATA_VALID && lat < 20);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL rvalid_latency: first RDATA_VALID after %0d cycles, required 3", lat);
        end
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (RDATA_VALID) n++;
            else break;
        end
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL read_throughput: %0d consecutive valid beats, required 4", n);
        end
        @(posedge CLK); #1;
        wait_drain("read_wrap");
    endtask

    task automatic test_backpressure();
        int w, ren0;
        RDATA_READY = 1'b0;
        ren0 = ren_count;
        push_read(10'h100, 7);
        issue_req(1'b0, 10'h100, 7, '0, w);
        repeat (12) @(negedge CLK);
        vectors++;
        if (ren_count - ren0 !== 2) begin
            miscompares++;
            $display("FAIL stall_reads: %0d SRAM_REN pulses while stalled, required 2", ren_count - ren0);
        end
        vectors++;
        if (RDATA_VALID !== 1'b1 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_state: RDATA_VALID %b BUSY %b, required 1 1", RDATA_VALID, BUSY);
        end
        @(posedge CLK); #1;
        RDATA_READY = 1'b1;
        wait_drain("backpressure");
        vectors++;
        if (ren_count - ren0 !== 8) begin
            miscompares++;
            $display("FAIL total_reads: %0d SRAM_REN pulses, required 8", ren_count - ren0);
        end
    endtask

    task automatic test_back_to_back();
        int w, k;
        bit early_idle;
        push_read(10'h200, 3);
        issue_req(1'b0, 10'h200, 3, '0, w);
        push_write(10'h300, 2, 4'hF, 32'hCAFE0000);
        issue_req(1'b1, 10'h300, 2, 4'hF, w);
        vectors++;
        if (rq.size() == 0) begin
            miscompares++;
            $display("FAIL accept_while_draining: 0 read beats pending at write accept, required >0");
        end
        drive_wdata(32'hCAFE0000, 2, 1'b0);
        early_idle = 1'b0;
        k = 0;
        while (BUSY && k < 40) begin
            @(negedge CLK); #1;
            k++;
        end
        if (rq.size() != 0 || wq.size() != 0) early_idle = 1'b1;
        vectors++;
        if (BUSY !== 1'b0 || early_idle) begin
            miscompares++;
            $display("FAIL busy_fall: BUSY %b with %0d reads %0d writes outstanding, required 0 with none", BUSY, rq.size(), wq.size());
        end
        @(posedge CLK); #1;
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid_read();
        int w;
        RDATA_READY = 1'b0;
        push_read(10'h040, 7);
        issue_req(1'b0, 10'h040, 7, '0, w);
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({RDATA_VALID, SRAM_MEN, SRAM_WEN, SRAM_REN, BUSY, REQ_READY} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_abort: RV MEN WEN REN BUSY RR = %b, required 000001",
                     {RDATA_VALID, SRAM_MEN, SRAM_WEN, SRAM_REN, BUSY, REQ_READY});
        end
        rq.delete();
        raq.delete();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        RDATA_READY = 1'b1;
        repeat (10) @(negedge CLK);
        @(posedge CLK); #1;
        push_read(10'h3FE, 1);
        issue_req(1'b0, 10'h3FE, 1, '0, w);
        wait_drain("post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pat(i);
        RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_LEN = '0;
        REQ_BE = '0; WDATA = '0; WDATA_VALID = 1'b0; RDATA_READY = 1'b1;
        test_reset();
        test_write();
        test_byte_enable();
        test_read_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
